// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared encodings for the simple CPU multiply/divide path:
//           operation codes, sequencer states and iteration count.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_pkg;

   // op[1] selects divide, op[0] selects unsigned
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   // Sequencer states of the iterative unit
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   // One shift-add or restoring-subtract step per cycle
   localparam int unsigned ITERATIONS = 32;

endpackage
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : mul_div_unit
// Brief   : Iterative 32x32 multiply / 32/32 divide with architectural HI/LO.
//           Magnitudes are processed for 32 cycles in a shared 64-bit shift
//           register through one 33-bit adder/subtractor, then sign-corrected
//           and committed to HI/LO. MTHI/MTLO are accepted while idle.
// Revision: 1.0 - initial release
// ============================================================================
module mul_div_unit
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             cancel,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int W2 = 2 * WIDTH;

   state_t             r_state;
   state_t             w_next;
   logic [4:0]         r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   // Latched operation context
   logic               r_is_div;
   logic               r_neg_q;     // product / quotient must be negated
   logic               r_neg_r;     // remainder must be negated
   logic               r_divz;      // divisor was zero
   logic [WIDTH-1:0]   r_a_raw;     // dividend as given, for divide-by-zero HI
   logic [WIDTH-1:0]   r_opnd;      // multiplicand or divisor magnitude
   logic [W2-1:0]      r_acc;       // shared shift register

   logic               w_accept;
   logic               w_last;
   logic               w_op_div;
   logic               w_op_signed;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH-1:0]   w_add_x;
   logic [WIDTH:0]     w_sum;
   logic               w_q_bit;
   logic [W2-1:0]      w_acc_step;
   logic [W2-1:0]      w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;

   assign w_accept    = (r_state == IDLE) && start && !cancel;
   assign w_last      = (r_cnt == 5'(ITERATIONS - 1));
   assign w_op_div    = op[1];
   assign w_op_signed = ~op[0];
   assign w_a_neg     = w_op_signed & src_a[WIDTH-1];
   assign w_b_neg     = w_op_signed & src_b[WIDTH-1];
   assign w_a_mag     = w_a_neg ? -src_a : src_a;
   assign w_b_mag     = w_b_neg ? -src_b : src_b;

   // Shared adder: multiply adds the multiplicand to the upper half; divide
   // subtracts the divisor from the upper half after a one-bit left shift.
   // The bit shifted out of the top acts as an implicit 33rd bit for divide.
   assign w_add_x  = r_is_div ? r_acc[W2-2:WIDTH-1] : r_acc[W2-1:WIDTH];
   assign w_sum    = r_is_div ? ({1'b0, w_add_x} - {1'b0, r_opnd})
                              : ({1'b0, w_add_x} + {1'b0, r_opnd});
   assign w_q_bit  = r_acc[W2-1] | ~w_sum[WIDTH];

   // One iteration of shift-add multiply or restoring divide
   always_comb begin
      w_acc_step = r_acc;
      if (r_is_div) begin
         if (w_q_bit) begin
            w_acc_step = {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
         end else begin
            w_acc_step = {r_acc[W2-2:0], 1'b0};
         end
      end else begin
         if (r_acc[0]) begin
            w_acc_step = {w_sum, r_acc[WIDTH-1:1]};
         end else begin
            w_acc_step = {1'b0, r_acc[W2-1:1]};
         end
      end
   end

   // Sign correction and special cases applied in FIX
   assign w_prod = r_neg_q ? -r_acc : r_acc;
   assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem  = r_neg_r ? -r_acc[W2-1:WIDTH] : r_acc[W2-1:WIDTH];

   always_comb begin
      w_res_hi = w_prod[W2-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
      if (r_is_div) begin
         if (r_divz) begin
            w_res_hi = r_a_raw;
            w_res_lo = '1;
         end else begin
            w_res_hi = w_rem;
            w_res_lo = w_quo;
         end
      end
   end

   // Next-state selection; cancel always returns to IDLE
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_accept) w_next = RUN;
         RUN: begin
            if (cancel) begin
               w_next = IDLE;
            end else if (w_last) begin
               w_next = FIX;
            end
         end
         FIX:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Iteration counter and registered busy/done flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_cnt  <= (r_state == RUN && !cancel) ? r_cnt + 5'd1 : 5'd0;
         r_busy <= (w_next != IDLE);
         r_done <= (r_state == FIX) && !cancel;
      end
   end

   // Operand capture on accept, one datapath step per RUN cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_divz   <= 1'b0;
         r_a_raw  <= '0;
         r_opnd   <= '0;
         r_acc    <= '0;
      end else if (w_accept) begin
         r_is_div <= w_op_div;
         r_neg_q  <= w_a_neg ^ w_b_neg;
         r_neg_r  <= w_a_neg;
         r_divz   <= (src_b == '0);
         r_a_raw  <= src_a;
         r_opnd   <= w_op_div ? w_b_mag : w_a_mag;
         r_acc    <= {{WIDTH{1'b0}}, (w_op_div ? w_a_mag : w_b_mag)};
      end else if (r_state == RUN) begin
         r_acc    <= w_acc_step;
      end
   end

   // HI/LO: result commit in FIX, MTHI/MTLO only while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (r_state == FIX) begin
         if (!cancel) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end
      end else if (r_state == IDLE) begin
         if (hi_we) r_hi <= wdata;
         if (lo_we) r_lo <= wdata;
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mul_div_unit
// Brief   : Directed self-checking bench for mul_div_unit with a result
//           scoreboard fed from a behavioural arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        cancel;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_cmp  = 0;
   int          n_fail = 0;
   int          cyc    = 0;
   int          bcnt   = 0;
   int          dcnt   = 0;
   logic [63:0] sb_q[$];
   logic [31:0] cur_hi = 32'h0;
   logic [31:0] cur_lo = 32'h0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .src_a  (src_a),
      .src_b  (src_b),
      .cancel (cancel),
      .hi_we  (hi_we),
      .lo_we  (lo_we),
      .wdata  (wdata),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference arithmetic: returns {HI, LO}
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [63:0] sq;
      logic signed [63:0] sr;
      sa = $signed(a);
      sb = $signed(b);
      case (o)
         2'b00: return sa * sb;
         2'b01: return {32'h0, a} * {32'h0, b};
         2'b10: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
         end
         default: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and record busy/done as seen mid-cycle
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (done) dcnt++;
   endtask

   // Present start for one cycle; optionally record the expected result
   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      if (push) sb_q.push_back(model(o, a, b));
      cyc  = 0;
      bcnt = 0;
      dcnt = 0;
      tick();
      start = 1'b0;
   endtask

   // Wait (bounded) for done, then check timing and the scoreboard entry
   task automatic wait_done(input string tag);
      logic [63:0] exp;
      while (!done && cyc < 60) tick();
      check({tag, "_done_cycle"}, 64'(cyc), 64'd34);
      check({tag, "_busy_cycles"}, 64'(bcnt), 64'd33);
      if (sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         check({tag, "_hi"}, {32'h0, hi}, {32'h0, exp[63:32]});
         check({tag, "_lo"}, {32'h0, lo}, {32'h0, exp[31:0]});
         cur_hi = exp[63:32];
         cur_lo = exp[31:0];
      end else begin
         check({tag, "_scoreboard_entry"}, 64'd0, 64'd1);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      op     = 2'b00;
      src_a  = 32'h0;
      src_b  = 32'h0;
      cancel = 1'b0;
      hi_we  = 1'b0;
      lo_we  = 1'b0;
      wdata  = 32'h0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_busy", {63'h0, busy}, 64'd0);
      check("rst_done", {63'h0, done}, 64'd0);
      check("rst_hi", {32'h0, hi}, 64'd0);
      check("rst_lo", {32'h0, lo}, 64'd0);
      rst_n = 1'b1;
      tick();

      // Arithmetic cases, issued back to back (start during done cycle)
      launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      wait_done("multu_max");
      check("multu_max_hi_const", {32'h0, hi}, 64'hFFFF_FFFE);
      launch(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1);
      wait_done("mult_neg");
      launch(2'b11, 32'd100, 32'd7, 1'b1);
      wait_done("divu_100_7");
      launch(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_done("div_m7_2");
      launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_done("div_ovf");
      launch(2'b11, 32'd5, 32'd0, 1'b1);
      wait_done("divu_by0");
      launch(2'b10, 32'hFFFF_FF00, 32'd0, 1'b1);
      wait_done("div_by0_neg");
      launch(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1);
      wait_done("mult_minmin");
      tick();

      // A second start while busy must be ignored
      launch(2'b01, 32'd6, 32'd7, 1'b1);
      repeat (4) tick();
      start = 1'b1;
      op    = 2'b11;
      src_a = 32'd100;
      src_b = 32'd3;
      tick();
      start = 1'b0;
      wait_done("start_ignored");
      tick();

      // Cancel at iteration 10: no done, HI/LO unchanged
      launch(2'b01, 32'd123, 32'd456, 1'b0);
      repeat (9) tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      check("cancel_busy", {63'h0, busy}, 64'd0);
      repeat (40) tick();
      check("cancel_no_done", 64'(dcnt), 64'd0);
      check("cancel_hi", {32'h0, hi}, {32'h0, cur_hi});
      check("cancel_lo", {32'h0, lo}, {32'h0, cur_lo});

      // Start together with cancel launches nothing
      start  = 1'b1;
      cancel = 1'b1;
      op     = 2'b01;
      src_a  = 32'd2;
      src_b  = 32'd2;
      tick();
      start  = 1'b0;
      cancel = 1'b0;
      check("start_cancel_busy", {63'h0, busy}, 64'd0);

      // MTHI while idle
      hi_we = 1'b1;
      wdata = 32'h0000_1234;
      tick();
      hi_we = 1'b0;
      check("mthi_idle", {32'h0, hi}, 64'h1234);
      check("mthi_lo_kept", {32'h0, lo}, {32'h0, cur_lo});
      cur_hi = 32'h0000_1234;

      // MTHI alongside an accepted start lands first, then is overwritten
      hi_we = 1'b1;
      wdata = 32'h0000_ABCD;
      launch(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1);
      hi_we = 1'b0;
      check("mthi_with_start", {32'h0, hi}, 64'hABCD);
      // MTLO while busy is ignored
      lo_we = 1'b1;
      wdata = 32'hDEAD_BEEF;
      tick();
      lo_we = 1'b0;
      check("mtlo_busy", {32'h0, lo}, {32'h0, cur_lo});
      wait_done("mult_after_mthi");
      tick();

      // Asynchronous reset mid-operation
      launch(2'b01, 32'd9, 32'd9, 1'b0);
      repeat (19) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", {63'h0, busy}, 64'd0);
      check("arst_done", {63'h0, done}, 64'd0);
      check("arst_hi", {32'h0, hi}, 64'd0);
      check("arst_lo", {32'h0, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      launch(2'b01, 32'd6, 32'd7, 1'b1);
      wait_done("multu_after_rst");
      check("multu_after_rst_42", {32'h0, lo}, 64'd42);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
